// File: rtl/wf_stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_e    : controller FSM states
//   COLON_*    : colon/decimal-point codes driven to the 7-seg display
//   bcd_time_t : six BCD digits, minutes-tens down to hundredths-units
//   disp_t     : four display digits plus colon code
//   fmt_disp() : picks SS.hh or MM:SS presentation for a time value
package wf_stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_LAP  = 3'd2,
    ST_STOP = 3'd3,
    ST_FULL = 3'd4
  } state_e;

  localparam logic [1:0] COLON_ON  = 2'b00;
  localparam logic [1:0] COLON_DP  = 2'b01;
  localparam logic [1:0] COLON_OFF = 2'b11;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] h1;
    logic [3:0] h0;
  } bcd_time_t;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [1:0] colon;
  } disp_t;

  // Below one minute (when auto-ranging) show SS.hh, otherwise MM:SS.
  function automatic disp_t fmt_disp(input bcd_time_t t, input logic auto_rng);
    disp_t d;
    d.colon = COLON_OFF;
    if (auto_rng && (t.m1 == 4'd0) && (t.m0 == 4'd0)) begin
      d.d3    = t.s1;
      d.d2    = t.s0;
      d.d1    = t.h1;
      d.d0    = t.h0;
      d.colon = COLON_DP;
    end else begin
      d.d3    = t.m1;
      d.d2    = t.m0;
      d.d1    = t.s1;
      d.d0    = t.s0;
      d.colon = COLON_ON;
    end
    return d;
  endfunction

endpackage

// File: rtl/wf_stopwatch_ctrl_if.sv
// Stopwatch controller bundle: button/tick pulses in, display digits and
// status out.
//   master : upstream side (drives tick and button pulses, observes display)
//   slave  : the controller itself
interface wf_stopwatch_ctrl_if;
  logic       tick;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [1:0] colon;
  logic       running;
  logic       full;

  modport master (
    output tick, start_stop, lap, clear,
    input  digit0, digit1, digit2, digit3, colon, running, full
  );

  modport slave (
    input  tick, start_stop, lap, clear,
    output digit0, digit1, digit2, digit3, colon, running, full
  );
endinterface

// File: rtl/wf_bcd_digit.sv
// One BCD counter digit, modulo MOD (10 or 6).
//   clk, reset : clock, async active-high reset
//   inc        : advance by one this cycle
//   clr        : synchronous zero (wins over inc)
//   q          : current digit value
//   carry      : inc while at MOD-1, i.e. this digit wraps this cycle
module wf_bcd_digit #(
  parameter int unsigned MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc)
      q_d = (q_q == LAST) ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc & (q_q == LAST);

endmodule

// File: rtl/wf_stopwatch_ctrl.sv
// Stopwatch controller feeding the 4-digit 7-segment display.
// Counts 10 ms ticks as BCD MM:SS.hh under a start/stop/lap/clear FSM and
// presents either SS.hh (under a minute) or MM:SS on the display.
//   clk, reset : clock, async active-high reset
//   sw (slave) : tick/start_stop/lap/clear pulses in;
//                digit0..3, colon, running, full out (all registered)
// Parameters:
//   MAX_MIN  : minute limit (1..99); count saturates at MAX_MIN:59.99
//   AUTO_RNG : 1 = SS.hh below one minute, 0 = always MM:SS
module wf_stopwatch_ctrl
  import wf_stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MIN  = 99,
  parameter bit          AUTO_RNG = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  wf_stopwatch_ctrl_if.slave   sw
);

  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  state_e    state_q, state_d;
  bcd_time_t snap_q, snap_d;
  disp_t     disp_q, disp_d;
  logic      running_q, running_d;
  logic      full_q, full_d;

  bcd_time_t        live;
  logic             counting;
  logic             at_max;
  logic             count_en;
  logic             clr_cnt;
  logic [5:0][3:0]  cnt;
  logic [5:0]       inc;
  logic [5:0]       carry;
  logic             top_carry_unused;

  // Digit chain, index 0 = hundredths units ... 5 = minutes tens.
  // Only the seconds-tens digit is modulo 6.
  assign inc[0] = count_en;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    wf_bcd_digit #(.MOD((i == 3) ? 6 : 10)) u_dig (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[i]),
      .clr   (clr_cnt),
      .q     (cnt[i]),
      .carry (carry[i])
    );
    if (i < 5) begin : g_chain
      assign inc[i+1] = carry[i];
    end
  end

  // Past MAX_MIN:59.99 the FSM saturates, so the top carry never matters.
  assign top_carry_unused = carry[5];

  assign live = {cnt[5], cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign at_max   = (live.m1 == MAX_M1) && (live.m0 == MAX_M0) &&
                    (live.s1 == 4'd5)   && (live.s0 == 4'd9)   &&
                    (live.h1 == 4'd9)   && (live.h0 == 4'd9);
  // Tick counting depends only on the current state, so a button pulse in
  // the same cycle does not swallow the tick.
  assign count_en = sw.tick & counting & ~at_max;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    clr_cnt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sw.start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sw.start_stop) begin
          state_d = ST_STOP;
        end else if (sw.lap) begin
          state_d = ST_LAP;
          snap_d  = live;
        end
      end
      ST_LAP: begin
        if (sw.start_stop) state_d = ST_STOP;
        else if (sw.lap)   state_d = ST_RUN;
      end
      ST_STOP: begin
        if (sw.clear) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end else if (sw.start_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_FULL: begin
        if (sw.clear) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick arriving at the limit pins the count; saturation overrides any
    // button pulse in the same cycle so the held value is always flagged.
    if (counting && sw.tick && at_max) state_d = ST_FULL;

    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    full_d    = (state_d == ST_FULL);
    disp_d    = fmt_disp((state_q == ST_LAP) ? snap_q : live, AUTO_RNG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      disp_q    <= '{d3: 4'd0, d2: 4'd0, d1: 4'd0, d0: 4'd0, colon: COLON_DP};
      running_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      full_q    <= full_d;
    end
  end

  assign sw.digit3  = disp_q.d3;
  assign sw.digit2  = disp_q.d2;
  assign sw.digit1  = disp_q.d1;
  assign sw.digit0  = disp_q.d0;
  assign sw.colon   = disp_q.colon;
  assign sw.running = running_q;
  assign sw.full    = full_q;

endmodule
